// File: rtl/as_pkg.sv
// as_pkg: allocation-set field widths, word layout and sequencer states
package as_pkg;
    localparam int VEC_ID_W       = 4;
    localparam int STAGE_W        = 3;
    localparam int DATA_ADDR_W    = 12;
    localparam int ALLOC_LEN_W    = 10;
    localparam int PS_ADDR_W      = 7;
    localparam int REGFILE_ADDR_W = 5;

    function automatic int as_width();
        return STAGE_W + VEC_ID_W + 2 * REGFILE_ADDR_W + ALLOC_LEN_W + 2 * DATA_ADDR_W;
    endfunction

    localparam int AS_W = as_width();

    localparam int DADDR_B_LSB   = 0;
    localparam int DADDR_A_LSB   = DADDR_B_LSB + DATA_ADDR_W;
    localparam int ALLOC_LEN_LSB = DADDR_A_LSB + DATA_ADDR_W;
    localparam int RF_B_LSB      = ALLOC_LEN_LSB + ALLOC_LEN_W;
    localparam int RF_A_LSB      = RF_B_LSB + REGFILE_ADDR_W;
    localparam int VEC_ID_LSB    = RF_A_LSB + REGFILE_ADDR_W;
    localparam int STAGE_LSB     = VEC_ID_LSB + VEC_ID_W;

    typedef enum logic [2:0] {IDLE, LOAD, ARMED, FETCH, ISSUE, WAIT} state_t;
endpackage

// File: rtl/as_sequencer.sv
// as_sequencer: loads the allocation-set list, then walks it once per sample strobe
module as_sequencer
    import as_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [AS_W-1:0]      cfg_word,
    input  logic                 cfg_last,
    input  logic                 run_start,
    output logic                 mem_prog,
    output logic [PS_ADDR_W-1:0] mem_psaddr,
    output logic [AS_W-1:0]      mem_prog_as,
    input  logic [AS_W-1:0]      mem_as_word,
    output logic                 iss_valid,
    input  logic                 iss_ready,
    output logic [AS_W-1:0]      iss_word,
    input  logic                 iss_done,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overrun,
    output logic [PS_ADDR_W:0]   prog_len
);
    state_t               state, state_n;
    logic [PS_ADDR_W-1:0] wptr, wptr_n, rptr, rptr_n;
    logic [PS_ADDR_W:0]   len_n;
    logic [AS_W-1:0]      word_n;
    logic                 phase, phase_n, valid_n, busy_n, fd, fd_n, ovr_n;

    assign cfg_ready   = state == LOAD;
    assign mem_prog    = en & cfg_valid & (state == LOAD);
    assign mem_psaddr  = state == LOAD ? wptr : rptr;
    assign mem_prog_as = state == LOAD ? cfg_word : '0;
    assign frame_done  = fd & en;

    // state register; with en low everything holds and the done pulse is dropped
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            wptr      <= '0;
            rptr      <= '0;
            phase     <= 1'b0;
            prog_len  <= '0;
            iss_valid <= 1'b0;
            iss_word  <= '0;
            busy      <= 1'b0;
            fd        <= 1'b0;
            overrun   <= 1'b0;
        end else if (en) begin
            state     <= state_n;
            wptr      <= wptr_n;
            rptr      <= rptr_n;
            phase     <= phase_n;
            prog_len  <= len_n;
            iss_valid <= valid_n;
            iss_word  <= word_n;
            busy      <= busy_n;
            fd        <= fd_n;
            overrun   <= ovr_n;
        end else begin
            fd <= 1'b0;
        end
    end

    // next state: load list, then per frame fetch (two cycles), issue, wait for done
    always_comb begin
        state_n = state;
        wptr_n  = wptr;
        rptr_n  = rptr;
        phase_n = phase;
        len_n   = prog_len;
        valid_n = iss_valid;
        word_n  = iss_word;
        busy_n  = busy;
        fd_n    = 1'b0;
        ovr_n   = overrun | (run_start & busy);
        case (state)
            IDLE: begin
                wptr_n  = '0;
                state_n = LOAD;
            end
            LOAD: if (cfg_valid) begin
                wptr_n = wptr + 1'b1;
                if (cfg_last || &wptr) begin
                    len_n   = {1'b0, wptr} + 1'b1;
                    state_n = ARMED;
                end
            end
            ARMED: if (run_start) begin
                if (prog_len == '0) fd_n = 1'b1;
                else begin
                    rptr_n  = '0;
                    phase_n = 1'b0;
                    busy_n  = 1'b1;
                    state_n = FETCH;
                end
            end
            FETCH: if (phase) begin
                word_n  = mem_as_word;
                valid_n = 1'b1;
                phase_n = 1'b0;
                state_n = ISSUE;
            end else begin
                phase_n = 1'b1;
            end
            ISSUE: if (iss_ready) begin
                valid_n = 1'b0;
                state_n = WAIT;
            end
            WAIT: if (iss_done) begin
                if ({1'b0, rptr} == prog_len - 1'b1) begin
                    busy_n  = 1'b0;
                    fd_n    = 1'b1;
                    state_n = ARMED;
                end else begin
                    rptr_n  = rptr + 1'b1;
                    state_n = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: doc/as_sequencer.md
Name: as_sequencer

Overview:
Controller for the allocation-set list memory. It has two jobs:
- Load phase: writes a program of allocation-set words into the list through a valid/ready config port.
- Run phase: on each sample strobe, walks the list from address 0 to prog_len-1. Each word is fetched, issued to the MAC/stage datapath with a valid/ready handshake, and the block waits for that datapath's done before moving on.

It sits between the host/config bus, the list memory and the datapath control.

Parameters:
VEC_ID_W, 4, vector id field width
STAGE_W, 3, stage field width
DATA_ADDR_W, 12, data address field width
ALLOC_LEN_W, 10, allocation length field width
PS_ADDR_W, 7, list address width (max 128 entries)
REGFILE_ADDR_W, 5, register file address field width
(AS_W = STAGE_W+VEC_ID_W+2*REGFILE_ADDR_W+ALLOC_LEN_W+2*DATA_ADDR_W = 51, derived)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
en  in  1  global enable; when low, FSM and all registers hold
cfg_valid  in  1  config word valid
cfg_ready  out  1  config word accepted (high only in LOAD)
cfg_word  in  AS_W  allocation-set word to store
cfg_last  in  1  marks final word of the program
run_start  in  1  one-cycle sample strobe that starts a frame
mem_prog  out  1  list write enable
mem_psaddr  out  PS_ADDR_W  list address
mem_prog_as  out  AS_W  list write data
mem_as_word  in  AS_W  list read data, valid 1 cycle after address
iss_valid  out  1  issued word valid
iss_ready  in  1  datapath accepts issued word
iss_word  out  AS_W  issued allocation-set word (held stable while iss_valid)
iss_done  in  1  datapath finished current allocation set
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after last entry's done
overrun  out  1  sticky: run_start while busy
prog_len  out  PS_ADDR_W+1  number of loaded entries

Behaviour:
- Reset (rst==0 at posedge): state=IDLE.
  - Outputs: cfg_ready=0, mem_prog=0, mem_psaddr=0, mem_prog_as=0, iss_valid=0, iss_word=0, busy=0, frame_done=0, overrun=0, prog_len=0.
  - Reset wins over every other input, including mid-frame and mid-load. No issue handshake completes in the reset cycle.
- en==0: all state holds; outputs keep their values, with pulses (frame_done, mem_prog) forced to 0.
- States: IDLE, LOAD, ARMED, FETCH, ISSUE, WAIT.
- IDLE -> LOAD: immediately after reset release. Counter wptr=0.
- LOAD:
  - cfg_ready=1.
  - On cfg_valid&cfg_ready: mem_prog=1, mem_psaddr=wptr, mem_prog_as=cfg_word, wptr++ (combinational write strobe in that cycle).
  - If cfg_last, or wptr reaches 2**PS_ADDR_W-1 (list full): prog_len=wptr+1, go to ARMED.
  - A run_start during LOAD is ignored; overrun stays unchanged.
- ARMED:
  - On run_start, if prog_len==0: frame_done pulses next cycle, no issue.
  - Otherwise: rptr=0, busy=1, go to FETCH.
- FETCH: mem_psaddr=rptr. Next cycle, latch mem_as_word into iss_word, set iss_valid=1, go to ISSUE. Fetch latency is 2 cycles from address to iss_valid.
- ISSUE: hold iss_valid and iss_word until iss_ready. On handshake: iss_valid=0, go to WAIT.
- WAIT: on iss_done:
  - If rptr==prog_len-1: busy=0, frame_done=1 for one cycle, go to ARMED.
  - Else: rptr++, go to FETCH.
- iss_done arriving together with the handshake in ISSUE is ignored. Done is only honoured in WAIT.
- run_start while busy:
  - overrun=1 (sticky until reset); the strobe is dropped and the current frame continues.
  - A run_start in the same cycle frame_done pulses is accepted as a new frame and is not an overrun.
- Wrap: rptr never exceeds prog_len-1. prog_len of 128 requires PS_ADDR_W+1 bits.
- Reprogramming is only possible via reset.

Decomposition:
- Package as_pkg holds:
  - the field width constants and the AS_W function;
  - the state enum;
  - field slice offsets (STAGE msb ... DATA_ADDR lsb order), shared with ASList and the datapath decoders.
- No natural sub-module; single FSM plus two pointers.

Test Plan:
- Reset then load 3 words (0x1, 0x2, 0x3) with cfg_last on the 3rd -> mem_prog pulses at addrs 0,1,2; prog_len=3; cfg_ready drops.
- run_start with iss_ready=1 and iss_done 4 cycles after each issue -> iss_word sequence 0x1, 0x2, 0x3, each 2 cycles after its fetch address; frame_done pulses once; busy low afterwards.
- Hold iss_ready=0 for 5 cycles on entry 1 -> iss_valid and iss_word stay constant and no address advance occurs.
- run_start mid-frame -> overrun=1 and persists; frame completes normally. run_start in the frame_done cycle -> new frame, overrun unchanged.
- Load 128 words without cfg_last -> auto-transition to ARMED, prog_len=128; a run issues 128 words then frame_done.
- rst=0 asserted during WAIT -> next cycle all outputs at reset values; the state machine returns to LOAD.
